// File: rtl/wb_mux_guard.sv
// wb_mux_guard: registered-decode Wishbone N-slave mux with burst locking, decode-miss/timeout errors and error capture
module wb_mux_guard #(
  parameter int                        NUM_SLAVES     = 10,
  parameter logic [NUM_SLAVES*32-1:0]  MATCH_ADDR     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]  MATCH_MASK     = {NUM_SLAVES{32'hffffffff}},
  parameter int                        TIMEOUT_CYCLES = 1024,
  parameter int                        ERRCNT_W       = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic [31:0]                wbm_adr_i,
  input  logic [31:0]                wbm_dat_i,
  input  logic [3:0]                 wbm_sel_i,
  input  logic                       wbm_we_i,
  input  logic                       wbm_cyc_i,
  input  logic                       wbm_stb_i,
  input  logic [2:0]                 wbm_cti_i,
  input  logic [1:0]                 wbm_bte_i,
  output logic [31:0]                wbm_dat_o,
  output logic                       wbm_ack_o,
  output logic                       wbm_err_o,
  output logic                       wbm_rty_o,
  output logic [NUM_SLAVES*32-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*32-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES*4-1:0]    wbs_sel_o,
  output logic [NUM_SLAVES-1:0]      wbs_we_o,
  output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbs_stb_o,
  output logic [NUM_SLAVES*3-1:0]    wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]    wbs_bte_o,
  input  logic [NUM_SLAVES*32-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]      wbs_err_i,
  input  logic [NUM_SLAVES-1:0]      wbs_rty_i,
  output logic [ERRCNT_W-1:0]        err_count_o,
  output logic [31:0]                last_err_adr_o,
  output logic                       last_err_type_o
);
  localparam int IDX_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, ACTIVE, DERR, TOUT} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] sel_idx, hit_idx;
  logic [31:0] adr_q;
  logic [CNT_W-1:0] tcnt;
  logic hit, active, resp, tout, err_evt;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((wbm_adr_i & MATCH_MASK[i*32 +: 32]) == MATCH_ADDR[i*32 +: 32]) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
  end
  assign active = state == ACTIVE;
  assign resp = wbs_ack_i[sel_idx] | wbs_err_i[sel_idx] | wbs_rty_i[sel_idx];
  assign tout = (TIMEOUT_CYCLES != 0) && wbm_cyc_i && wbm_stb_i && !resp && tcnt == CNT_LAST;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (wbm_cyc_i && wbm_stb_i) state_nxt = hit ? ACTIVE : DERR;
      ACTIVE:  state_nxt = !wbm_cyc_i ? IDLE :
                           resp ? (wbm_cti_i == 3'b010 ? ACTIVE : IDLE) :
                           tout ? TOUT : ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end
  assign err_evt = state_nxt == DERR || state_nxt == TOUT;
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};
  assign wbs_cyc_o = active ? NUM_SLAVES'(wbm_cyc_i) << sel_idx : '0;
  assign wbs_stb_o = active ? NUM_SLAVES'(wbm_stb_i) << sel_idx : '0;
  assign wbm_dat_o = active ? wbs_dat_i[{sel_idx, 5'd0} +: 32] : '0;
  assign wbm_ack_o = active & wbm_cyc_i & wbs_ack_i[sel_idx];
  assign wbm_rty_o = active & wbm_cyc_i & wbs_rty_i[sel_idx];
  assign wbm_err_o = (active & wbm_cyc_i & wbs_err_i[sel_idx]) | state == DERR | state == TOUT;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state <= IDLE;
      sel_idx <= '0;
      adr_q <= '0;
      tcnt <= '0;
      err_count_o <= '0;
      last_err_adr_o <= '0;
      last_err_type_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        sel_idx <= hit_idx;
        adr_q <= wbm_adr_i;
      end
      tcnt <= (!active || resp) ? '0 : tcnt + CNT_W'(wbm_stb_i);
      if (err_evt) begin
        err_count_o <= &err_count_o ? err_count_o : err_count_o + 1'b1;
        last_err_adr_o <= state_nxt == DERR ? wbm_adr_i : adr_q;
        last_err_type_o <= state_nxt == TOUT;
      end
    end
endmodule

// File: tb/tb_wb_mux_guard.sv
// tb_wb_mux_guard: randomized scoreboard bench for wb_mux_guard (3 slaves, 8-cycle timeout, 2-bit error counter)
module tb_wb_mux_guard;
  localparam int N = 3;
  localparam int TO = 8;
  localparam int EW = 2;
  localparam logic [N*32-1:0] ADDR = {32'h2000, 32'h1000, 32'h0000};
  localparam logic [N*32-1:0] MASK = {N{32'hfffff000}};
  typedef struct {
    logic [2:0]   kind;
    logic [31:0]  dat;
    logic [N-1:0] stb;
  } exp_t;
  logic wb_clk_i, wb_rst_n_i;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic [3:0] wbm_sel_i;
  logic wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [2:0] wbm_cti_i;
  logic [1:0] wbm_bte_i;
  logic [N*32-1:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [N*4-1:0] wbs_sel_o;
  logic [N-1:0] wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [N*3-1:0] wbs_cti_o;
  logic [N*2-1:0] wbs_bte_o;
  logic [EW-1:0] err_count_o;
  logic [31:0] last_err_adr_o;
  logic last_err_type_o;
  exp_t q[$];
  int tests = 0, fails = 0;
  int smode[N], sdly[N], scnt[N];
  logic [31:0] sdat[N];
  logic stray[N];
  int m_cnt;
  logic [31:0] m_adr;
  logic m_type;

  wb_mux_guard #(.NUM_SLAVES(N), .MATCH_ADDR(ADDR), .MATCH_MASK(MASK),
                 .TIMEOUT_CYCLES(TO), .ERRCNT_W(EW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .err_count_o(err_count_o), .last_err_adr_o(last_err_adr_o), .last_err_type_o(last_err_type_o)
  );

  initial begin
    wb_clk_i = 0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & 32'hfffff000) == 32'(i) * 32'h1000) return i;
    return -1;
  endfunction

  function automatic void model_err(input logic [31:0] a, input logic t);
    m_cnt = m_cnt == (1 << EW) - 1 ? m_cnt : m_cnt + 1;
    m_adr = a;
    m_type = t;
  endfunction

  // Behavioural slaves: respond after sdly stalled cycles, or never when smode==3
  initial begin
    bit go;
    wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0; wbs_dat_i = '0;
    forever begin
      @(posedge wb_clk_i); #2;
      for (int i = 0; i < N; i++) begin
        go = 0;
        if (wb_rst_n_i && wbs_cyc_o[i] && wbs_stb_o[i]) begin
          if (smode[i] != 3 && scnt[i] >= sdly[i]) begin
            go = 1;
            scnt[i] = 0;
          end else scnt[i]++;
        end else scnt[i] = 0;
        wbs_ack_i[i] = (go && smode[i] == 0) || stray[i];
        wbs_err_i[i] = go && smode[i] == 1;
        wbs_rty_i[i] = go && smode[i] == 2;
        wbs_dat_i[i*32 +: 32] = sdat[i];
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_n_i && (wbm_ack_o || wbm_err_o || wbm_rty_o)) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got ack/err/rty=%b%b%b, expected none", wbm_ack_o, wbm_err_o, wbm_rty_o);
        end else begin
          e = q.pop_front();
          chk("resp_kind", {wbm_ack_o, wbm_err_o, wbm_rty_o}, e.kind);
          chk("resp_stb", wbs_stb_o, e.stb);
          if (e.kind == 3'b100) chk("resp_dat", wbm_dat_o, e.dat);
        end
      end
    end
  end

  task automatic check_regs();
    chk("err_count", err_count_o, m_cnt);
    chk("last_err_adr", last_err_adr_o, m_adr);
    chk("last_err_type", last_err_type_o, m_type);
  endtask

  task automatic run_txn(input logic [31:0] adr, input logic we, input int blen_in);
    int idx, blen, stbc, exp_stbc, got, cyc;
    logic [31:0] a;
    exp_t e;
    idx = decode(adr);
    blen = (idx >= 0 && smode[idx] == 0) ? blen_in : 1;
    e.dat = '0;
    e.stb = '0;
    if (idx < 0) begin
      e.kind = 3'b010;
      q.push_back(e);
      model_err(adr, 1'b0);
      exp_stbc = 0;
    end else if (smode[idx] == 3) begin
      e.kind = 3'b010;
      q.push_back(e);
      model_err(adr, 1'b1);
      exp_stbc = TO;
    end else begin
      e.kind = smode[idx] == 0 ? 3'b100 : smode[idx] == 1 ? 3'b010 : 3'b001;
      e.dat = sdat[idx];
      e.stb[idx] = 1'b1;
      for (int b = 0; b < blen; b++) q.push_back(e);
      exp_stbc = blen * (sdly[idx] + 1);
    end
    @(posedge wb_clk_i); #1;
    wbm_adr_i = adr; wbm_we_i = we; wbm_dat_i = $urandom; wbm_sel_i = 4'hf;
    wbm_cti_i = blen > 1 ? 3'b010 : 3'b000; wbm_bte_i = 2'b00;
    wbm_cyc_i = 1; wbm_stb_i = 1;
    a = adr; got = 0; stbc = 0; cyc = 0;
    while (got < blen && cyc < 60) begin
      @(negedge wb_clk_i);
      cyc++;
      if (cyc == 1) chk("bcast_adr", wbs_adr_o, {N{adr}});
      if (|wbs_stb_o) stbc++;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        got++;
        @(posedge wb_clk_i); #1;
        if (got < blen) begin
          a += 4;
          wbm_adr_i = a;
          wbm_cti_i = got == blen - 1 ? 3'b111 : 3'b010;
        end
      end
    end
    wbm_cyc_i = 0; wbm_stb_i = 0; wbm_cti_i = 3'b000;
    chk("beats", got, blen);
    chk("stb_cycles", stbc, exp_stbc);
    @(negedge wb_clk_i);
    chk("idle_dat", wbm_dat_o, 32'h0);
    check_regs();
  endtask

  initial begin
    wb_rst_n_i = 0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 0;
    wbm_cyc_i = 0; wbm_stb_i = 0; wbm_cti_i = '0; wbm_bte_i = '0;
    for (int i = 0; i < N; i++) begin
      smode[i] = 0; sdly[i] = 0; scnt[i] = 0; sdat[i] = $urandom; stray[i] = 0;
    end
    m_cnt = 0; m_adr = '0; m_type = 0;
    repeat (3) @(negedge wb_clk_i);
    check_regs();
    chk("rst_strobes", {wbs_cyc_o, wbs_stb_o}, '0);
    chk("rst_resp", {wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o}, '0);
    @(posedge wb_clk_i); #3;
    wb_rst_n_i = 1;
    smode[1] = 0; sdly[1] = 1;
    run_txn(32'h1004, 1'b0, 1);
    run_txn(32'h5000, 1'b0, 1);
    smode[2] = 3;
    run_txn(32'h2000, 1'b1, 1);
    @(posedge wb_clk_i); #1;
    stray[2] = 1;
    repeat (2) @(posedge wb_clk_i);
    #1 stray[2] = 0;
    @(negedge wb_clk_i);
    check_regs();
    smode[1] = 0; sdly[1] = 7;
    run_txn(32'h1000, 1'b0, 1);
    smode[0] = 0; sdly[0] = 0;
    run_txn(32'h0ff8, 1'b0, 4);
    smode[1] = 3;
    @(posedge wb_clk_i); #1;
    wbm_adr_i = 32'h1008; wbm_cti_i = 3'b000; wbm_cyc_i = 1; wbm_stb_i = 1;
    repeat (3) @(negedge wb_clk_i);
    chk("abort_pre_stb", wbs_stb_o, 3'b010);
    @(posedge wb_clk_i); #1;
    wbm_cyc_i = 0; wbm_stb_i = 0;
    #1 chk("abort_strobes", {wbs_cyc_o, wbs_stb_o}, '0);
    @(negedge wb_clk_i);
    check_regs();
    smode[1] = 0; sdly[1] = 0;
    run_txn(32'h1010, 1'b0, 1);
    smode[2] = 3;
    @(posedge wb_clk_i); #1;
    wbm_adr_i = 32'h2010; wbm_cyc_i = 1; wbm_stb_i = 1;
    repeat (4) @(negedge wb_clk_i);
    chk("pre_rst_stb", wbs_stb_o, 3'b100);
    #2 wb_rst_n_i = 0;
    m_cnt = 0; m_adr = '0; m_type = 0;
    #1;
    chk("async_rst_strobes", {wbs_cyc_o, wbs_stb_o}, '0);
    chk("async_rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, '0);
    check_regs();
    wbm_cyc_i = 0; wbm_stb_i = 0;
    @(posedge wb_clk_i); #3;
    wb_rst_n_i = 1;
    run_txn(32'h7000, 1'b0, 1);
    run_txn(32'h8000_0000, 1'b1, 1);
    run_txn(32'h3ffc, 1'b0, 1);
    run_txn(32'h0001_0000, 1'b0, 1);
    chk("err_saturated", err_count_o, 2'd3);
    for (int t = 0; t < 40; t++) begin
      logic [31:0] adr;
      int m;
      adr = 32'(($urandom_range(0, 4) * 32'h1000) + ($urandom_range(0, 1023) << 2));
      if ($urandom_range(0, 7) == 0) adr = $urandom;
      for (int i = 0; i < N; i++) begin
        m = $urandom_range(0, 9);
        smode[i] = m < 7 ? 0 : m - 6;
        sdly[i] = $urandom_range(0, 3);
        sdat[i] = $urandom;
      end
      run_txn(adr, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
    end
    repeat (2) @(negedge wb_clk_i);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
